// File: rtl/servo_pwm_gen.sv
// Servo pulse generator: clamps and double-buffers width commands, then applies them at timebase wrap.
// Optional failsafe (return to neutral width after a command timeout) is enabled by SERVO_PWM_FAILSAFE_EN.
module servo_pwm_gen #(
  parameter int CNT_W            = 12,
  parameter int PERIOD_MAX       = 3000,
  parameter int PW_MIN           = 1000,
  parameter int PW_MAX           = 2000,
  parameter int PW_NEUTRAL       = 1500,
  parameter int FAILSAFE_PERIODS = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_val,
  input  logic [CNT_W-1:0] cmd_pw,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic [CNT_W-1:0] active_pw,
  output logic             clamped,
  output logic             failsafe,
  output logic [1:0]       dbg_state
);

  // Handshake: a command transfers on any rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on registered state, and the source must hold cmd_pw while cmd_valid waits.

  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'd0,
    ST_IDLE      = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAILSAFE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] L_PERIOD_MAX = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] L_PW_MIN     = CNT_W'(PW_MIN);
  localparam logic [CNT_W-1:0] L_PW_MAX     = CNT_W'(PW_MAX);
  localparam logic [CNT_W-1:0] L_PW_NEUTRAL = CNT_W'(PW_NEUTRAL);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt_q, r_shadow, r_active_pw, w_active_next, w_cmd_clamped;
  logic             r_pending, r_pwm, r_period_start, r_clamped;
  logic             w_boundary, w_accept, w_load, w_clamp_lo, w_clamp_hi;
  logic             w_fs_trip, w_fs_last, w_drive, w_pwm_next;

  assign w_boundary    = (cnt_val == '0) && (r_cnt_q != '0);
  assign w_accept      = cmd_valid && !r_pending;
  assign w_load        = w_boundary && r_pending;
  assign w_clamp_lo    = cmd_pw < L_PW_MIN;
  assign w_clamp_hi    = cmd_pw > L_PW_MAX;
  assign w_cmd_clamped = w_clamp_lo ? L_PW_MIN : (w_clamp_hi ? L_PW_MAX : cmd_pw);

  always_comb begin
    w_state_next  = r_state;
    w_active_next = r_active_pw;
    w_fs_trip     = 1'b0;
    case (r_state)
      ST_WAIT_SYNC: if (w_boundary) w_state_next = r_pending ? ST_RUN : ST_IDLE;
      ST_IDLE:      if (w_load) w_state_next = ST_RUN;
      ST_RUN: begin
        if (w_load) w_state_next = ST_RUN;
        else if (w_boundary && w_fs_last) begin
          w_fs_trip    = 1'b1;
          w_state_next = ST_FAILSAFE;
        end
      end
      ST_FAILSAFE:  if (w_load) w_state_next = ST_RUN;
      default:      w_state_next = ST_WAIT_SYNC;
    endcase
    if (w_load) w_active_next = r_shadow;
    else if (w_fs_trip) w_active_next = L_PW_NEUTRAL;
  end

  // Width is compared against the value being loaded this cycle so a new width starts cleanly at count 0.
  assign w_drive    = (w_state_next == ST_RUN) || (w_state_next == ST_FAILSAFE);
  assign w_pwm_next = w_drive && (cnt_val <= L_PERIOD_MAX) && (cnt_val < w_active_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_WAIT_SYNC;
      r_cnt_q        <= '0;
      r_shadow       <= '0;
      r_active_pw    <= '0;
      r_pending      <= 1'b0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_clamped      <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt_q        <= cnt_val;
      r_active_pw    <= w_active_next;
      r_pwm          <= w_pwm_next;
      r_period_start <= w_boundary;
      r_clamped      <= w_accept && (w_clamp_lo || w_clamp_hi);
      if (w_accept) begin
        r_shadow  <= w_cmd_clamped;
        r_pending <= 1'b1;
      end else if (w_load) begin
        r_pending <= 1'b0;
      end
    end
  end

`ifdef SERVO_PWM_FAILSAFE_EN
  localparam int FS_W = $clog2(FAILSAFE_PERIODS + 1);

  logic [FS_W-1:0] r_fs_cnt;
  logic            r_failsafe;

  assign w_fs_last = (r_fs_cnt == FS_W'(FAILSAFE_PERIODS - 1));

  // Counts boundaries spent in RUN without a fresh load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fs_cnt   <= '0;
      r_failsafe <= 1'b0;
    end else if (w_load) begin
      r_fs_cnt   <= '0;
      r_failsafe <= 1'b0;
    end else if (w_fs_trip) begin
      r_fs_cnt   <= '0;
      r_failsafe <= 1'b1;
    end else if ((r_state == ST_RUN) && w_boundary) begin
      r_fs_cnt   <= r_fs_cnt + FS_W'(1);
    end
  end

  assign failsafe = r_failsafe;
`else
  assign w_fs_last = 1'b0;
  assign failsafe  = 1'b0;
`endif

  assign cmd_ready    = !r_pending;
  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;
  assign active_pw    = r_active_pw;
  assign clamped      = r_clamped;
  assign dbg_state    = r_state;

endmodule
